// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared display constants and segment pattern types
// Segment encodings are shared by the scan driver's encoder and the scan decoder.
package calc_pkg;

  localparam int NumDigits = 4;

  typedef enum logic [1:0] {
    SEG_HEX,
    SEG_BLANK,
    SEG_MINUS,
    SEG_UNKNOWN
  } seg_kind_t;

  // Active-high {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [7:0] SegHexPatterns [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [7:0] SegMinus = 8'h40;
  localparam logic [7:0] SegBlank = 8'h00;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational 7-segment pattern classifier
// Bits [6:0] select the class and hex value; bit 7 is the decimal point.
module seg_pattern_decode
  import calc_pkg::*;
(
  input  logic [7:0] pattern_i,
  output seg_kind_t  kind_o,
  output logic [3:0] value_o,
  output logic       dp_o
);

  always_comb begin
    kind_o  = SEG_UNKNOWN;
    value_o = 4'h0;
    dp_o    = pattern_i[7];
    if (pattern_i[6:0] == SegBlank[6:0]) begin
      kind_o = SEG_BLANK;
    end else if (pattern_i[6:0] == SegMinus[6:0]) begin
      kind_o = SEG_MINUS;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pattern_i[6:0] == SegHexPatterns[i][6:0]) begin
          kind_o  = SEG_HEX;
          value_o = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// rtl/segment_scan_decoder.sv - rebuilds digits from a multiplexed 7-segment scan
// Define SEG_DECODER_INPUT_SYNC_EN to add a two-flop synchronizer on the scan inputs.
module segment_scan_decoder
  import calc_pkg::*;
#(
  parameter int NumDigits        = calc_pkg::NumDigits,
  parameter int MinDwell         = 4,
  parameter int StableFrames     = 2,
  parameter int TimeoutCycles    = 1 << 20,
  parameter bit AnodeActiveLow   = 1'b1,
  parameter bit CathodeActiveLow = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 segments_cathode_i,
  input  logic [NumDigits-1:0]       segments_anode_i,
  output logic [NumDigits-1:0][7:0]  segments_o,
  output seg_kind_t [NumDigits-1:0]  digit_kind_o,
  output logic [NumDigits-1:0][3:0]  digit_value_o,
  output logic [NumDigits-1:0]       dp_o,
  output logic                       frame_valid_o,
  output logic                       update_o,
  output logic                       multi_anode_err_o
);

  localparam int         IW          = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int         TW          = $clog2(TimeoutCycles + 1);
  localparam logic [7:0] DwellMax    = 8'(MinDwell);
  localparam logic [3:0] StableMax   = 4'(StableFrames);
  localparam logic [TW-1:0] TimeoutLast = TW'(TimeoutCycles - 1);

  logic [NumDigits-1:0] anode_raw;
  logic [7:0]           cathode_raw;

`ifdef SEG_DECODER_INPUT_SYNC_EN
  localparam logic [NumDigits-1:0] AnodeIdle   = {NumDigits{AnodeActiveLow}};
  localparam logic [7:0]           CathodeIdle = {8{CathodeActiveLow}};

  logic [NumDigits-1:0] anode_meta_q, anode_sync_q;
  logic [7:0]           cathode_meta_q, cathode_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      anode_meta_q   <= AnodeIdle;
      anode_sync_q   <= AnodeIdle;
      cathode_meta_q <= CathodeIdle;
      cathode_sync_q <= CathodeIdle;
    end else begin
      anode_meta_q   <= segments_anode_i;
      anode_sync_q   <= anode_meta_q;
      cathode_meta_q <= segments_cathode_i;
      cathode_sync_q <= cathode_meta_q;
    end
  end

  assign anode_raw   = anode_sync_q;
  assign cathode_raw = cathode_sync_q;
`else
  assign anode_raw   = segments_anode_i;
  assign cathode_raw = segments_cathode_i;
`endif

  logic [NumDigits-1:0] anode_act;
  logic [7:0]           cathode_act;

  assign anode_act   = anode_raw ^ {NumDigits{AnodeActiveLow}};
  assign cathode_act = cathode_raw ^ {8{CathodeActiveLow}};

  logic [NumDigits-1:0]      prev_anode_q, prev_anode_d;
  logic [7:0]                dwell_q, dwell_d;
  logic [NumDigits-1:0][7:0] cap_q, cap_d;
  logic [NumDigits-1:0]      seen_q, seen_d;
  logic                      done_q, done_d;
  logic [NumDigits-1:0][7:0] last_frame_q, last_frame_d;
  logic [3:0]                stable_q, stable_d;
  logic                      pub_req_q, pub_req_d;
  logic [TW-1:0]             timeout_q, timeout_d;
  logic [NumDigits-1:0][7:0] segs_q, segs_d;
  seg_kind_t [NumDigits-1:0] kind_q, kind_d;
  logic [NumDigits-1:0][3:0] value_q, value_d;
  logic [NumDigits-1:0]      dp_q, dp_d;
  logic                      valid_q, valid_d;
  logic                      update_q, update_d;
  logic                      err_q, err_d;

  seg_kind_t [NumDigits-1:0] dec_kind;
  logic [NumDigits-1:0][3:0] dec_value;
  logic [NumDigits-1:0]      dec_dp;

  for (genvar g = 0; g < NumDigits; g++) begin : g_dec
    seg_pattern_decode u_dec (
      .pattern_i (last_frame_q[g]),
      .kind_o    (dec_kind[g]),
      .value_o   (dec_value[g]),
      .dp_o      (dec_dp[g])
    );
  end

  logic                      any_active, one_hot, multi_active, same_pat, capture, completion, frame_same;
  logic [IW-1:0]             idx;
  logic [NumDigits-1:0]      seen_nxt;
  logic [NumDigits-1:0][7:0] cap_nxt;

  always_comb begin
    prev_anode_d = anode_act;
    dwell_d      = dwell_q;
    cap_d        = cap_q;
    seen_d       = seen_q;
    done_d       = 1'b0;
    last_frame_d = last_frame_q;
    stable_d     = stable_q;
    pub_req_d    = 1'b0;
    timeout_d    = timeout_q;
    segs_d       = segs_q;
    kind_d       = kind_q;
    value_d      = value_q;
    dp_d         = dp_q;
    valid_d      = valid_q;
    update_d     = 1'b0;

    any_active   = (anode_act != '0);
    one_hot      = any_active && ((anode_act & (anode_act - NumDigits'(1))) == '0);
    multi_active = any_active && !one_hot;
    err_d        = err_q | multi_active;

    idx = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (anode_act[i]) idx = IW'(i);
    end

    // Dwell counts the current visit; zero means the previous cycle was blanking.
    same_pat = one_hot && (anode_act == prev_anode_q) && (dwell_q != 8'd0);
    if (!one_hot) begin
      dwell_d = 8'd0;
    end else if (same_pat) begin
      dwell_d = (dwell_q == DwellMax) ? dwell_q : dwell_q + 8'd1;
    end else begin
      dwell_d = 8'd1;
    end
    capture = one_hot && (dwell_d == DwellMax) && !(same_pat && (dwell_q == DwellMax));

    seen_nxt = done_q ? '0 : seen_q;
    cap_nxt  = cap_q;
    if (capture) begin
      cap_nxt[idx]  = cathode_act;
      seen_nxt[idx] = 1'b1;
    end
    completion = capture && (&seen_nxt);
    frame_same = (cap_nxt == last_frame_q);
    cap_d      = cap_nxt;
    seen_d     = seen_nxt;
    done_d     = completion;

    if (completion) begin
      timeout_d = '0;
      if (frame_same) begin
        stable_d = (stable_q == StableMax) ? stable_q : stable_q + 4'd1;
      end else begin
        last_frame_d = cap_nxt;
        stable_d     = 4'd1;
      end
      pub_req_d = (stable_d == StableMax) && !(frame_same && (stable_q == StableMax));
    end else if (timeout_q == TimeoutLast) begin
      timeout_d = '0;
      valid_d   = 1'b0;
      seen_d    = '0;
      done_d    = 1'b0;
      stable_d  = 4'd0;
    end else begin
      timeout_d = timeout_q + TW'(1);
    end

    if (pub_req_q) begin
      segs_d   = last_frame_q;
      kind_d   = dec_kind;
      value_d  = dec_value;
      dp_d     = dec_dp;
      valid_d  = 1'b1;
      update_d = (last_frame_q != segs_q) || !valid_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_anode_q <= '0;
      dwell_q      <= '0;
      cap_q        <= '0;
      seen_q       <= '0;
      done_q       <= 1'b0;
      last_frame_q <= '0;
      stable_q     <= '0;
      pub_req_q    <= 1'b0;
      timeout_q    <= '0;
      segs_q       <= '0;
      for (int i = 0; i < NumDigits; i++) kind_q[i] <= SEG_BLANK;
      value_q      <= '0;
      dp_q         <= '0;
      valid_q      <= 1'b0;
      update_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_anode_q <= prev_anode_d;
      dwell_q      <= dwell_d;
      cap_q        <= cap_d;
      seen_q       <= seen_d;
      done_q       <= done_d;
      last_frame_q <= last_frame_d;
      stable_q     <= stable_d;
      pub_req_q    <= pub_req_d;
      timeout_q    <= timeout_d;
      segs_q       <= segs_d;
      kind_q       <= kind_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
      err_q        <= err_d;
    end
  end

  assign segments_o        = segs_q;
  assign digit_kind_o      = kind_q;
  assign digit_value_o     = value_q;
  assign dp_o              = dp_q;
  assign frame_valid_o     = valid_q;
  assign update_o          = update_q;
  assign multi_anode_err_o = err_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// tb/tb_segment_scan_decoder.sv - self-checking bench for segment_scan_decoder
// Table of frames with expected decodes; published results checked through a scoreboard queue.
module tb_segment_scan_decoder;
  import calc_pkg::*;

  localparam int ND = 4;
  localparam int MD = 4;
  localparam int SF = 2;
  localparam int TO = 300;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          cath = 8'hFF;
  logic [ND-1:0]       anode = 4'hF;
  logic [ND-1:0][7:0]  segs_w;
  seg_kind_t [ND-1:0]  kind_w;
  logic [ND-1:0][3:0]  value_w;
  logic [ND-1:0]       dp_w;
  logic                valid_w, update_w, err_w;

  segment_scan_decoder #(
    .NumDigits(ND), .MinDwell(MD), .StableFrames(SF), .TimeoutCycles(TO),
    .AnodeActiveLow(1'b1), .CathodeActiveLow(1'b1)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .segments_cathode_i (cath),
    .segments_anode_i   (anode),
    .segments_o         (segs_w),
    .digit_kind_o       (kind_w),
    .digit_value_o      (value_w),
    .dp_o               (dp_w),
    .frame_valid_o      (valid_w),
    .update_o           (update_w),
    .multi_anode_err_o  (err_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pat;
    logic [7:0]  kind;
    logic [15:0] val;
    logic [3:0]  dp;
    longint      cyc;
  } vec_t;

  vec_t   vecs [4];
  vec_t   sb [$];
  vec_t   mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     upd_cnt = 0;
  int     upd_base;
  longint cyc = 0;
  logic [7:0] all_blank;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && update_w) begin
      upd_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_update", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("segments", segs_w, mon_e.pat);
        check("kind", kind_w, mon_e.kind);
        check("value", value_w, mon_e.val);
        check("dp", dp_w, mon_e.dp);
        check("valid_at_update", valid_w, 1);
        check("update_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic scan_digit(input int d, input logic [7:0] pat, input int n);
    logic [3:0] one;
    one   = 4'b0001;
    anode = ~(one << d);
    cath  = ~pat;
    repeat (n) @(negedge clk);
  endtask

  // Scans digits 0..3; when push_v >= 0 the publish is expected from this frame.
  task automatic scan_frame(input logic [31:0] pats, input int push_v);
    vec_t e;
    for (int d = 0; d < 4; d++) begin
      if (d == 3 && push_v >= 0) begin
        e     = vecs[push_v];
        e.cyc = cyc + MD + 1;
        sb.push_back(e);
      end
      scan_digit(d, pats[d*8 +: 8], 8);
    end
  endtask

  task automatic publish_vec(input int v);
    scan_frame(vecs[v].pat, -1);
    scan_frame(vecs[v].pat, v);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_segments"}, segs_w, 0);
    check({tag, "_kind"}, kind_w, all_blank);
    check({tag, "_value"}, value_w, 0);
    check({tag, "_dp"}, dp_w, 0);
    check({tag, "_valid"}, valid_w, 0);
    check({tag, "_update"}, update_w, 0);
    check({tag, "_err"}, err_w, 0);
  endtask

  initial begin
    all_blank = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    vecs[0] = '{pat: {8'h66, 8'h4F, 8'h5B, 8'h06}, kind: {SEG_HEX, SEG_HEX, SEG_HEX, SEG_HEX},
                val: {4'h4, 4'h3, 4'h2, 4'h1}, dp: 4'b0000, cyc: 0};
    vecs[1] = '{pat: {8'hBF, 8'h12, 8'h00, 8'h40}, kind: {SEG_HEX, SEG_UNKNOWN, SEG_BLANK, SEG_MINUS},
                val: 16'h0000, dp: 4'b1000, cyc: 0};
    vecs[2] = '{pat: {8'h71, 8'h7C, 8'h77, 8'h3F}, kind: {SEG_HEX, SEG_HEX, SEG_HEX, SEG_HEX},
                val: {4'hF, 4'hB, 4'hA, 4'h0}, dp: 4'b0000, cyc: 0};
    vecs[3] = '{pat: {8'h6F, 8'hB9, 8'h5E, 8'hF9}, kind: {SEG_HEX, SEG_HEX, SEG_HEX, SEG_HEX},
                val: {4'h9, 4'hC, 4'hD, 4'hE}, dp: 4'b0101, cyc: 0};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) publish_vec(v);
    repeat (4) @(negedge clk);
    check("table_update_count", upd_cnt, 4);
    check("table_sb_drained", sb.size(), 0);

    // Glitch onto digit 2 after its real visit must not replace the captured value.
    publish_vec(0);
    upd_base = upd_cnt;
    for (int f = 0; f < 2; f++) begin
      scan_digit(2, 8'h4F, 8);
      scan_digit(0, 8'h06, 8);
      scan_digit(1, 8'h5B, 8);
      scan_digit(2, 8'h7F, 1);
      scan_digit(3, 8'h66, 8);
    end
    repeat (4) @(negedge clk);
    check("glitch_no_update", upd_cnt - upd_base, 0);
    check("glitch_digit2", segs_w[2], 8'h4F);

    // Alternating frames never stabilise.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_base = upd_cnt;
    for (int f = 0; f < 4; f++) begin
      scan_frame((f % 2 == 0) ? {8'h00, 8'h00, 8'h5B, 8'h06} : {8'h00, 8'h00, 8'h4F, 8'h06}, -1);
    end
    check("alt_valid", valid_w, 0);
    check("alt_no_update", upd_cnt - upd_base, 0);

    // Two anodes at once.
    anode = 4'b1100;
    cath  = ~8'h7F;
    repeat (5) @(negedge clk);
    check("multi_err_set", err_w, 1);
    publish_vec(0);
    check("multi_err_sticky", err_w, 1);
    check("multi_then_valid", valid_w, 1);

    // Scan stops: data goes stale but is retained.
    upd_base = upd_cnt;
    anode = 4'hF;
    cath  = 8'hFF;
    repeat (100) @(negedge clk);
    check("timeout_not_yet", valid_w, 1);
    repeat (250) @(negedge clk);
    check("timeout_valid", valid_w, 0);
    check("timeout_segments_held", segs_w, vecs[0].pat);
    check("timeout_no_update", upd_cnt - upd_base, 0);
    publish_vec(0);
    check("resume_valid", valid_w, 1);
    check("resume_err_sticky", err_w, 1);

    // Asynchronous reset in the middle of a frame.
    scan_digit(0, 8'h40, 8);
    scan_digit(1, 8'h00, 3);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    publish_vec(2);
    repeat (4) @(negedge clk);
    check("final_sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
